// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA controller stepping by 2 bits per cycle, then 1
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d, result_q, result_d, shifted;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               two;

    // One shift step on the work register: 2 bits while at least 2 remain, else the final 1 bit
    always_comb begin
        two     = rem_q[SHAMT_W-1:1] != '0;
        shifted = op_q == 2'b00 ? (two ? work_q << 2 : work_q << 1) :
                  op_q == 2'b10 ? (two ? WIDTH'($signed(work_q) >>> 2) : WIDTH'($signed(work_q) >>> 1)) :
                                  (two ? work_q >> 2 : work_q >> 1);
    end

    // Next-state and datapath updates; result is captured on the edge that enters DONE
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (start) begin
                work_d  = data_in;
                rem_d   = shamt;
                op_d    = op;
                state_d = (shamt == '0 || op == 2'b11) ? DONE : SHIFT;
            end
            SHIFT: begin
                work_d  = shifted;
                rem_d   = two ? rem_q - SHAMT_W'(2) : '0;
                state_d = rem_d == '0 ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        result_d = state_d == DONE ? work_d : result_q;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer with directed vectors
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result=%h", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result got=%h exp=%h", result, e.res);
                end
                checks++;
                if (cyc - e.t0 + 1 != e.lat) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - e.t0 + 1, e.lat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        op = o; data_in = d; shamt = s; start = 1'b1;
        e.res = exp; e.lat = lat; e.t0 = cyc + 1;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        data_in = $urandom; shamt = 5'($urandom); op = 2'($urandom);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d", q.size());
            q.delete();
        end
        @(negedge clk);
        #1;
        check("busy_after_done", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        // Reset with start held high: nothing may launch
        @(negedge clk);
        rst = 1'b1; start = 1'b1; data_in = 32'hDEADBEEF; shamt = 5'd3; op = 2'b01;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'h0);

        issue(2'b01, 32'hF0000000, 5'd3,  32'h1E000000, 3,  1'b1); drain();
        issue(2'b10, 32'h80000000, 5'd4,  32'hF8000000, 3,  1'b1); drain();
        issue(2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 17, 1'b1); drain();
        issue(2'b00, 32'h00000001, 5'd31, 32'h80000000, 17, 1'b1); drain();
        issue(2'b00, 32'h00000001, 5'd0,  32'h00000001, 1,  1'b1); drain();
        issue(2'b01, 32'h80000000, 5'd31, 32'h00000001, 17, 1'b1); drain();
        issue(2'b11, 32'hA5A5A5A5, 5'd7,  32'hA5A5A5A5, 1,  1'b1); drain();
        issue(2'b10, 32'h40000000, 5'd5,  32'h02000000, 4,  1'b1); drain();

        // Starts during SHIFT and during DONE are ignored
        issue(2'b00, 32'h00000003, 5'd8, 32'h00000300, 5, 1'b1);
        start = 1'b1; data_in = 32'h12345678; shamt = 5'd1; op = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; data_in = 32'h0000FFFF; shamt = 5'd2; op = 2'b00;
        @(negedge clk);
        start = 1'b0;
        #1;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("no_relaunch_busy", {31'b0, busy}, 32'h0);
        end
        check("held_result", result, 32'h00000300);

        // Reset mid-operation abandons the shift without a done pulse
        issue(2'b10, 32'hFFFF0000, 5'd20, 32'h0, 11, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h0);
        repeat (12) @(negedge clk);
        issue(2'b00, 32'h00000001, 5'd2, 32'h00000004, 2, 1'b1); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
